// File: rtl/spi_master_tx.sv
// SPI mode-0 write-only master: accepts one word per valid/ready handshake and
// shifts it out MSB first on cs/sclk/mosi, with every output driven from a flop.
module spi_master_tx #(
    parameter int reg_width = 8,
    parameter int clk_div   = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [reg_width-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 cs,
    output logic                 mosi,
    output logic                 sclk
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    localparam int pw = $clog2(clk_div + 1);
    localparam int bw = $clog2(reg_width);
    localparam logic [pw-1:0] phase_load = pw'(clk_div - 1);
    localparam logic [bw-1:0] bit_load   = bw'(reg_width - 1);

    state_t               state, state_nx;
    logic [pw-1:0]        phase, phase_nx;
    logic [bw-1:0]        bit_cnt, bit_nx;
    logic [reg_width-1:0] shift, shift_nx;

    logic accept;
    logic phase_end;
    logic cs_nx, sclk_nx, mosi_nx, ready_nx, busy_nx, done_nx;

    assign accept    = tx_valid && tx_ready;
    assign phase_end = (phase == '0);

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        bit_nx   = bit_cnt;
        shift_nx = shift;

        if (state != IDLE && !phase_end)
            phase_nx = phase - 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SETUP;
                    phase_nx = phase_load;
                    bit_nx   = bit_load;
                    shift_nx = tx_data;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_nx = HIGH;
                    phase_nx = phase_load;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    phase_nx = phase_load;
                    if (bit_cnt == '0) begin
                        state_nx = HOLD;
                    end else begin
                        // Advance the data on the falling edge so it is stable for the next rise.
                        state_nx = LOW;
                        bit_nx   = bit_cnt - 1'b1;
                        shift_nx = {shift[reg_width-2:0], 1'b0};
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_nx = HIGH;
                    phase_nx = phase_load;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_nx = GAP;
                    phase_nx = phase_load;
                end
            end
            GAP: begin
                if (phase_end)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops present them in step with it.
        cs_nx    = !(state_nx inside {SETUP, HIGH, LOW, HOLD});
        sclk_nx  = (state_nx == HIGH);
        mosi_nx  = (state_nx inside {IDLE, GAP}) ? 1'b1 : shift_nx[reg_width-1];
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state_nx == GAP) && (state != GAP);
        ready_nx = (state_nx == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            bit_cnt  <= bit_nx;
            shift    <= shift_nx;
            cs       <= cs_nx;
            sclk     <= sclk_nx;
            mosi     <= mosi_nx;
            tx_ready <= ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule
